// File: rtl/twiddle_pkg.sv
// Shared constants and types for the twiddle-factor RAM write path.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: data/address widths, beat count of a full load, FSM state enum,
// and a helper that turns a RAM index into a one-hot enable vector.
package twiddle_pkg;
   localparam int D_W         = 64;   // coefficient width
   localparam int MA_W        = 4;    // MA address width
   localparam int A_W         = 6;    // RAM address width = MA_W + 2
   localparam int N_ROM       = 3;    // RAM pairs written in sequence
   localparam int B_W         = 4;    // coefficient-within-MA counter width
   localparam int R_W         = 2;    // RAM index counter width
   localparam int TOTAL_BEATS = 768;  // N_ROM * 16 MA * 16 coefficients
   localparam int BEATS_PER_ROM = (1 << MA_W) * (1 << B_W);
   localparam int LAST_ROM    = TOTAL_BEATS / BEATS_PER_ROM - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [N_ROM-1:0] rom_onehot(input logic [R_W-1:0] r);
      return N_ROM'(1) << r;
   endfunction
endpackage

// File: rtl/twiddle_ram_writer_packer.sv
// Packs coefficient pairs into double-width RAM words and registers the write.
// Latency: write issued 1 clk after the odd beat of a pair is accepted.
// Backpressure: none here; only sees beats already accepted by the top.
// Ports: clk/rst; beat_acc + beat_dat + coef/ma/rom indices of the accepted beat;
//        wr_addr/wr_data/wr_en_b0/wr_en_b1 registered RAM write port.
module twiddle_pair_packer
   import twiddle_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 beat_acc,
   input  logic [D_W-1:0]       beat_dat,
   input  logic [B_W-1:0]       coef_idx,
   input  logic [MA_W-1:0]      ma_idx,
   input  logic [R_W-1:0]       rom_idx,
   output logic [A_W-1:0]       wr_addr,
   output logic [2*D_W-1:0]     wr_data,
   output logic [N_ROM-1:0]     wr_en_b0,
   output logic [N_ROM-1:0]     wr_en_b1
);
   logic [D_W-1:0]   half_q, half_d;
   logic [A_W-1:0]   addr_q, addr_d;
   logic [2*D_W-1:0] data_q, data_d;
   logic [N_ROM-1:0] en_b0_q, en_b0_d;
   logic [N_ROM-1:0] en_b1_q, en_b1_d;

   always_comb begin
      half_d  = half_q;
      addr_d  = addr_q;
      data_d  = data_q;
      en_b0_d = '0;
      en_b1_d = '0;
      if (beat_acc) begin
         if (!coef_idx[0]) begin
            half_d = beat_dat;
         end else begin
            data_d = {beat_dat, half_q};
            // coef_idx[3:2] selects the group, coef_idx[1] the bank within it
            addr_d = {coef_idx[3:2], ma_idx};
            if (coef_idx[1]) en_b1_d = rom_onehot(rom_idx);
            else             en_b0_d = rom_onehot(rom_idx);
         end
      end
   end

   // Async reset drops the enables immediately and discards a half pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         en_b0_q <= '0;
         en_b1_q <= '0;
      end else begin
         half_q  <= half_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         en_b0_q <= en_b0_d;
         en_b1_q <= en_b1_d;
      end
   end

   assign wr_addr  = addr_q;
   assign wr_data  = data_q;
   assign wr_en_b0 = en_b0_q;
   assign wr_en_b1 = en_b1_q;
endmodule

// File: rtl/twiddle_ram_writer.sv
// Write side of the twiddle store: loads 768 coefficients into RAM0..RAM2 banks B0/B1.
// Latency: RAM write 1 clk after the odd beat of each pair; done 1 clk after beat 767 is accepted.
// Backpressure: in_ready low outside LOAD or while hold is high; pending writes still issue.
// Ports: clk, rst, start, hold, in_valid/in_data/in_last/in_ready stream,
//        wr_addr/wr_data/wr_en_b0/wr_en_b1 RAM write port, busy/done/err status.
module twiddle_ram_writer
   import twiddle_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 hold,
   input  logic                 in_valid,
   input  logic [D_W-1:0]       in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [A_W-1:0]       wr_addr,
   output logic [2*D_W-1:0]     wr_data,
   output logic [N_ROM-1:0]     wr_en_b0,
   output logic [N_ROM-1:0]     wr_en_b1,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   state_t           state_q, state_d;
   logic [B_W-1:0]   b_q, b_d;
   logic [MA_W-1:0]  m_q, m_d;
   logic [R_W-1:0]   r_q, r_d;
   logic             err_q, err_d;
   logic             accept;
   logic             last_beat;

   assign in_ready  = (state_q == LOAD) && !hold;
   assign accept    = in_valid && in_ready;
   assign last_beat = (r_q == R_W'(LAST_ROM)) && (m_q == '1) && (b_q == '1);

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      m_d     = m_q;
      r_d     = r_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               b_d     = '0;
               m_d     = '0;
               r_d     = '0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               b_d = b_q + B_W'(1);
               if (b_q == '1) begin
                  m_d = m_q + MA_W'(1);
                  // The RAM index parks at 0 after the final beat so it never reaches 3.
                  if (m_q == '1) r_d = last_beat ? '0 : r_q + R_W'(1);
               end
               if (in_last != last_beat) err_d = 1'b1;
               if (last_beat) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         b_q     <= '0;
         m_q     <= '0;
         r_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         m_q     <= m_d;
         r_q     <= r_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q == LOAD);
   assign done = (state_q == DONE);
   assign err  = err_q;

   twiddle_pair_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .beat_acc (accept),
      .beat_dat (in_data),
      .coef_idx (b_q),
      .ma_idx   (m_q),
      .rom_idx  (r_q),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_en_b0 (wr_en_b0),
      .wr_en_b1 (wr_en_b1)
   );
endmodule
